// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle ARM-subset control FSM with a registered NZCV flag
//            register. Optional multiply support is enabled by CTRL_MUL_EN.
// Revision : 1.0
// ============================================================================
module mc_control #(
    parameter int         ALUCTRL_W = 3,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           MulFn,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
`ifdef CTRL_MUL_EN
        , S_MULEX = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_target;
    logic [3:0] r_flags;
    logic       r_condex;
    logic       w_condex;
    logic       w_condex_next;
    logic [3:0] w_cmd;
    logic [2:0] w_alu_dp;
    logic       w_exec;
    logic       w_flag_we;
    logic       w_cv_we;
    logic       w_n, w_z, w_c, w_v;

    logic       w_pcwrite, w_regwrite, w_memwrite, w_irwrite, w_adrsrc;
    logic [1:0] w_resultsrc, w_alusrca, w_alusrcb;
    logic [2:0] w_aluctl;

    assign w_cmd = Funct[4:1];
    assign {w_n, w_z, w_c, w_v} = r_flags;

`ifdef CTRL_MUL_EN
    logic w_is_mul;
    assign w_is_mul = (Op == 2'b00) && !Funct[5] && (w_cmd == 4'b0000) && (MulFn == 4'b1001);
    assign w_exec   = (r_state == S_EXECR) || (r_state == S_EXECI) || (r_state == S_MULEX);
`else
    logic w_unused_mulfn;
    assign w_unused_mulfn = ^MulFn;
    assign w_exec         = (r_state == S_EXECR) || (r_state == S_EXECI);
`endif

    always_comb begin
        w_condex = 1'b0;
        case (Cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = !w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = !w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = !w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = !w_v;
            4'b1000: w_condex = w_c && !w_z;
            4'b1001: w_condex = !w_c || w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = !w_z && (w_n == w_v);
            4'b1101: w_condex = w_z || (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_dp = 3'd0;
        case (w_cmd)
            4'b0100: w_alu_dp = 3'd0;
            4'b0010: w_alu_dp = 3'd1;
            4'b0000: w_alu_dp = 3'd2;
            4'b1100: w_alu_dp = 3'd3;
            4'b0001: w_alu_dp = 3'd4;
            default: w_alu_dp = 3'd0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    2'b00: begin
                        if (Funct[5]) begin
                            w_next = S_EXECI;
                        end else begin
                            w_next = S_EXECR;
`ifdef CTRL_MUL_EN
                            if (w_is_mul) w_next = S_MULEX;
`endif
                        end
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
`ifdef CTRL_MUL_EN
            S_MULEX:  w_next = S_ALUWB;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered
    // together with the condition result that state will see.
    assign w_target      = reset ? S_FETCH : w_next;
    assign w_condex_next = reset ? 1'b0 : ((r_state == S_DECODE) ? w_condex : r_condex);

    always_comb begin
        w_pcwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluctl    = 3'd0;
        case (w_target)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_pcwrite   = 1'b1;
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_DECODE: begin
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_MEMADR: w_alusrcb = 2'b01;
            S_MEMRD:  w_adrsrc  = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = w_condex_next;
                w_pcwrite   = w_condex_next && (Rd == 4'hF);
            end
            S_MEMWR: begin
                w_adrsrc   = 1'b1;
                w_memwrite = w_condex_next;
            end
            S_EXECR: w_aluctl = w_alu_dp;
            S_EXECI: begin
                w_alusrcb = 2'b01;
                w_aluctl  = w_alu_dp;
            end
`ifdef CTRL_MUL_EN
            S_MULEX: w_aluctl = 3'd5;
`endif
            S_ALUWB: begin
                w_regwrite = w_condex_next;
                w_pcwrite  = w_condex_next && (Rd == 4'hF);
            end
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_pcwrite   = w_condex_next;
            end
            default: ;
        endcase
    end

    // C and V only carry meaning for ADD/SUB; other ops leave them untouched.
    assign w_flag_we = w_exec && Funct[0] && r_condex;
    assign w_cv_we   = w_flag_we && ((w_cmd == 4'b0100) || (w_cmd == 4'b0010));

    always_ff @(posedge clk) begin
        r_state    <= w_target;
        r_condex   <= w_condex_next;
        PCWrite    <= w_pcwrite;
        RegWrite   <= w_regwrite;
        MemWrite   <= w_memwrite;
        IRWrite    <= w_irwrite;
        AdrSrc     <= w_adrsrc;
        ResultSrc  <= w_resultsrc;
        ALUSrcA    <= w_alusrca;
        ALUSrcB    <= w_alusrcb;
        ALUControl <= ALUCTRL_W'(w_aluctl);
        if (reset) begin
            r_flags <= FLAGS_RST;
        end else begin
            if (w_flag_we) r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_we)   r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign Flags  = r_flags;
    assign State  = r_state;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Self-checking bench for mc_control: instruction-level model plus
//            hand-computed literal pins. Honours CTRL_MUL_EN like the design.
// Revision : 1.0
// ============================================================================
module tb_mc_control;

`ifdef CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] MulFn;
    logic [3:0] ALUFlags;
    logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;
    logic [3:0] State;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .MulFn      (MulFn),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .State      (State)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        bit         pcw, regw, memw, irw;
        int         alu;
        logic [3:0] flags;
        logic [1:0] imm, regsrc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         seen_st[$], seen_pcw[$], seen_regw[$], seen_memw[$], seen_alu[$];
    logic [3:0] m_flags;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;            // EQ
            4'h1: return !z;           // NE
            4'h2: return cf;           // CS
            4'h3: return !cf;          // CC
            4'h4: return n;            // MI
            4'h5: return !n;           // PL
            4'h6: return v;            // VS
            4'h7: return !v;           // VC
            4'h8: return cf && !z;     // HI
            4'h9: return !cf || z;     // LS
            4'hA: return n == v;       // GE
            4'hB: return n != v;       // LT
            4'hC: return !z && n == v; // GT
            4'hD: return z || n != v;  // LE
            4'hE: return 1'b1;         // AL
            default: return 1'b0;
        endcase
    endfunction

    function automatic int alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return 4;
            default: return 0;
        endcase
    endfunction

    // Leading 1 nibble records the sequence length alongside its contents.
    function automatic logic [31:0] pack(input int q[$]);
        logic [31:0] r = 32'd1;
        foreach (q[i]) r = (r << 4) | 32'(q[i] & 15);
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            seen_st.push_back(int'(State));
            seen_pcw.push_back(int'(PCWrite));
            seen_regw.push_back(int'(RegWrite));
            seen_memw.push_back(int'(MemWrite));
            seen_alu.push_back(int'(ALUControl));
            chk("state",    32'(State),    32'(cur.st));
            chk("pcwrite",  32'(PCWrite),  32'(cur.pcw));
            chk("regwrite", 32'(RegWrite), 32'(cur.regw));
            chk("memwrite", 32'(MemWrite), 32'(cur.memw));
            chk("irwrite",  32'(IRWrite),  32'(cur.irw));
            chk("flags",    32'(Flags),    32'(cur.flags));
            chk("immsrc",   32'(ImmSrc),   32'(cur.imm));
            chk("regsrc",   32'(RegSrc),   32'(cur.regsrc));
            if (cur.alu >= 0) chk("alucontrol", 32'(ALUControl), 32'(cur.alu));
            if (cur.st == 0) begin
                chk("fetch_adrsrc",    32'(AdrSrc),    32'd0);
                chk("fetch_resultsrc", 32'(ResultSrc), 32'd2);
                chk("fetch_alusrca",   32'(ALUSrcA),   32'd1);
                chk("fetch_alusrcb",   32'(ALUSrcB),   32'd2);
            end
        end
    end

    // Starts in a FETCH cycle; abort_at >= 0 asserts reset during that step.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] mf, input logic [3:0] af,
                             input int abort_at);
        int         seq[$];
        bit         cx, mul;
        logic [3:0] nf;
        exp_t       e;
        int         n;
        Cond = c; Op = op; Funct = f; Rd = rd; MulFn = mf; ALUFlags = af;
        cx  = cond_holds(c, m_flags);
        mul = MUL_EN && (op == 2'b00) && !f[5] && (f[4:1] == 4'b0000) && (mf == 4'b1001);
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            2'b00: begin
                seq.push_back(f[5] ? 7 : (mul ? 10 : 6));
                seq.push_back(8);
            end
            2'b01: begin
                seq.push_back(2);
                if (f[0]) begin
                    seq.push_back(3);
                    seq.push_back(4);
                end else begin
                    seq.push_back(5);
                end
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        nf = m_flags;
        if (op == 2'b00 && f[0] && cx) begin
            nf[3:2] = af[3:2];
            if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) nf[1:0] = af[1:0];
        end
        seen_st.delete(); seen_pcw.delete(); seen_regw.delete();
        seen_memw.delete(); seen_alu.delete();
        n = (abort_at >= 0) ? abort_at + 1 : seq.size();
        for (int i = 0; i < n; i++) begin
            e.st     = seq[i];
            e.irw    = (seq[i] == 0);
            e.pcw    = (seq[i] == 0) || (seq[i] == 9 && cx) ||
                       ((seq[i] == 4 || seq[i] == 8) && cx && rd == 4'hF);
            e.regw   = (seq[i] == 4 || seq[i] == 8) && cx;
            e.memw   = (seq[i] == 5) && cx;
            e.alu    = (seq[i] == 0) ? 0 :
                       (seq[i] == 6 || seq[i] == 7) ? alu_code(f[4:1]) :
                       (seq[i] == 10) ? 5 : -1;
            e.flags  = (i == seq.size() - 1) ? nf : m_flags;
            e.imm    = op;
            e.regsrc = {op == 2'b01, op == 2'b10};
            exp_q.push_back(e);
        end
        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            m_flags = 4'b0000;
        end else begin
            m_flags = nf;
            repeat (seq.size()) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; Cond = '0; Op = '0; Funct = '0; Rd = '0; MulFn = '0; ALUFlags = '0;
        m_flags = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",   32'(State),   32'd0);
        chk("reset_flags",   32'(Flags),   32'h0);
        chk("reset_irwrite", 32'(IRWrite), 32'd1);
        chk("reset_pcwrite", 32'(PCWrite), 32'd1);
        reset = 1'b0;

        // ORR S=1, ALUFlags=1011 from 0000: N,Z load, C,V hold
        run_instr(4'hE, 2'b00, 6'b011001, 4'd2, 4'd0, 4'b1011, -1);
        chk("orr_flags",  32'(Flags),     32'h8);
        chk("orr_states", pack(seen_st),  32'h10168);

        // BEQ with Z=0: not taken
        run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'd0, 4'b0000, -1);
        chk("beq_nt_states",  pack(seen_st),  32'h1019);
        chk("beq_nt_pcwrite", pack(seen_pcw), 32'h1100);

        // ADD R1,R2,R3 S=1, ALUFlags=0110
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'd0, 4'b0110, -1);
        chk("add_flags",    32'(Flags),      32'h6);
        chk("add_states",   pack(seen_st),   32'h10168);
        chk("add_regwrite", pack(seen_regw), 32'h10001);

        // BEQ with Z=1: taken
        run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'd0, 4'b0000, -1);
        chk("beq_t_pcwrite", pack(seen_pcw), 32'h1101);

        // LDR: five cycles, RegWrite only in MEMWB
        run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'd0, 4'b0000, -1);
        chk("ldr_states",   pack(seen_st),   32'h101234);
        chk("ldr_regwrite", pack(seen_regw), 32'h100001);

        // STR with NE while Z=1: no MemWrite
        run_instr(4'h1, 2'b01, 6'b011000, 4'd5, 4'd0, 4'b0000, -1);
        chk("str_nv_states",   pack(seen_st),   32'h10125);
        chk("str_nv_memwrite", pack(seen_memw), 32'h10000);

        // SUB S=1 under GE: all four flags load
        run_instr(4'hA, 2'b00, 6'b000101, 4'd3, 4'd0, 4'b1001, -1);
        chk("sub_flags", 32'(Flags), 32'h9);

        // ADD immediate under GT to R15: PC written in ALUWB
        run_instr(4'hC, 2'b00, 6'b101000, 4'hF, 4'd0, 4'b0000, -1);
        chk("addi_states",  pack(seen_st),  32'h10178);
        chk("addi_pcwrite", pack(seen_pcw), 32'h11001);

        // Cond=1111 never executes
        run_instr(4'hF, 2'b00, 6'b011001, 4'd6, 4'd0, 4'b0000, -1);
        chk("nv_flags",    32'(Flags),      32'h9);
        chk("nv_regwrite", pack(seen_regw), 32'h10000);

        // Op=11 returns to FETCH after DECODE
        run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, 4'b0000, -1);
        chk("op11_states", pack(seen_st), 32'h101);

        // Unlisted cmd with S=1: ALUControl 0, C,V hold
        run_instr(4'hE, 2'b00, 6'b010101, 4'd7, 4'd0, 4'b0100, -1);
        chk("cmd_other_flags", 32'(Flags), 32'h5);

        // Multiply encoding
        run_instr(4'hE, 2'b00, 6'b000000, 4'd8, 4'b1001, 4'b1111, -1);
`ifdef CTRL_MUL_EN
        chk("mul_states", pack(seen_st), 32'h101a8);
        chk("mul_alu", 32'(seen_alu.size() > 2 ? seen_alu[2] : -1), 32'd5);
`else
        chk("mul_states", pack(seen_st), 32'h10168);
        chk("mul_alu", 32'(seen_alu.size() > 2 ? seen_alu[2] : -1), 32'd2);
`endif

        // STR interrupted by reset while in MEMWR
        run_instr(4'hE, 2'b01, 6'b011000, 4'd9, 4'd0, 4'b0000, 3);
        chk("abort_memwr_seen", pack(seen_memw), 32'h10001);
        chk("abort_state",      32'(State),      32'd0);
        chk("abort_memwrite",   32'(MemWrite),   32'd0);
        chk("abort_flags",      32'(Flags),      32'h0);

        // EOR S=1 after reset
        run_instr(4'hE, 2'b00, 6'b000011, 4'd1, 4'd0, 4'b1110, -1);
        chk("eor_flags", 32'(Flags), 32'hC);

        // LDR to R15: PC written in MEMWB
        run_instr(4'hE, 2'b01, 6'b011001, 4'hF, 4'd0, 4'b0000, -1);
        chk("ldr_pc_pcwrite", pack(seen_pcw), 32'h110001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
